// File: rtl/rmii_rx_frame_ctrl.sv
// rmii_rx_frame_ctrl: frame-level gate between the RMII_RX byte stream and the RX data FIFO.
// Forwards bytes one cycle late. Enforces the MIN_LEN/MAX_LEN frame length limits.
// Aborts a frame on FIFO almost-full and reports one status pulse per frame.
// Optional macro RX_FRAME_CNT_EN builds the saturating good/dropped frame counters;
// when it is undefined, frame_cnt and drop_cnt are tied to zero.
// Ports:
//   REF_CLK, arst_n            clock and asynchronous active-low reset
//   rx_en                      host receive enable, sampled on the first byte of a frame
//   in_din/in_wren/in_EOD      byte stream from RMII_RX
//   fifo_afull, rx_afull       FIFO almost-full in, back-pressure out to RMII_RX
//   out_din/out_wren/out_EOD/out_abort   registered write port to the data FIFO
//   stat_valid, stat_len, stat_runt/long/ovf/dis   per-frame status, held until next pulse
//   frame_cnt, drop_cnt        good / flagged frame counters
module rmii_rx_frame_ctrl #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11
) (
    input  logic             REF_CLK,
    input  logic             arst_n,
    input  logic             rx_en,
    input  logic [7:0]       in_din,
    input  logic             in_wren,
    input  logic             in_EOD,
    output logic             rx_afull,
    input  logic             fifo_afull,
    output logic [7:0]       out_din,
    output logic             out_wren,
    output logic             out_EOD,
    output logic             out_abort,
    output logic             stat_valid,
    output logic [LEN_W-1:0] stat_len,
    output logic             stat_runt,
    output logic             stat_long,
    output logic             stat_ovf,
    output logic             stat_dis,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      drop_cnt
);
    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
    state_t state, state_n;
    logic [LEN_W-1:0] len, len_inc;
    logic dis, take, long_hit, runt_hit, bad, rep;

    // the first byte of a frame always counts as length 1
    assign len_inc  = (state == IDLE) ? LEN_W'(1) : (&len) ? len : len + LEN_W'(1);
    assign take     = in_wren & ((state == RECV) | ((state == IDLE) & rx_en));
    assign long_hit = len_inc == LEN_W'(MAX_LEN + 1);
    assign runt_hit = len_inc < LEN_W'(MIN_LEN);
    // an accepted byte under afull or past MAX_LEN becomes the abort marker
    assign bad      = fifo_afull | long_hit;
    // aborted frames already reported at the marker; disabled frames report at EOD
    assign rep      = take ? (in_EOD | bad) : (in_wren & in_EOD & ((state == IDLE) | dis));
    assign rx_afull = fifo_afull | (state == DROP);

    always_comb begin
        state_n = state;
        if (in_wren)
            state_n = in_EOD ? IDLE : (take & !bad) ? RECV : DROP;
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            len        <= '0;
            dis        <= 1'b0;
            out_din    <= '0;
            out_wren   <= 1'b0;
            out_EOD    <= 1'b0;
            out_abort  <= 1'b0;
            stat_valid <= 1'b0;
            stat_len   <= '0;
            stat_runt  <= 1'b0;
            stat_long  <= 1'b0;
            stat_ovf   <= 1'b0;
            stat_dis   <= 1'b0;
        end else begin
            if (in_wren)
                len <= len_inc;
            if (in_wren & (state == IDLE))
                dis <= !rx_en;
            out_wren  <= take;
            out_EOD   <= take & (in_EOD | bad);
            out_abort <= take & (bad | (in_EOD & runt_hit));
            if (take)
                out_din <= bad ? 8'h00 : in_din;
            stat_valid <= rep;
            if (rep) begin
                stat_len  <= len_inc;
                stat_runt <= take & !bad & runt_hit;
                stat_long <= take & long_hit;
                stat_ovf  <= take & fifo_afull;
                stat_dis  <= !take;
            end
        end
    end

`ifdef RX_FRAME_CNT_EN
    logic flagged;
    assign flagged = stat_runt | stat_long | stat_ovf | stat_dis;

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else if (stat_valid) begin
            if (!flagged && !(&frame_cnt))
                frame_cnt <= frame_cnt + 16'd1;
            if (flagged && !(&drop_cnt))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif
endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// tb_rmii_rx_frame_ctrl: frame-level reference model bench for rmii_rx_frame_ctrl.
// Frames are described by length, enable, afull position.
// Expected per-cycle outputs are derived from those frame rules and queued.
module tb_rmii_rx_frame_ctrl;
    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1518;
    localparam int LEN_W   = 11;
    localparam int SAT     = (1 << LEN_W) - 1;

    logic REF_CLK = 1'b0;
    logic arst_n = 1'b1;
    logic rx_en = 1'b0, in_wren = 1'b0, in_EOD = 1'b0, fifo_afull = 1'b0;
    logic [7:0] in_din = 8'h00;
    logic rx_afull, out_wren, out_EOD, out_abort, stat_valid;
    logic stat_runt, stat_long, stat_ovf, stat_dis;
    logic [7:0] out_din;
    logic [LEN_W-1:0] stat_len;
    logic [15:0] frame_cnt, drop_cnt;

    rmii_rx_frame_ctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .REF_CLK(REF_CLK), .arst_n(arst_n), .rx_en(rx_en), .in_din(in_din),
        .in_wren(in_wren), .in_EOD(in_EOD), .rx_afull(rx_afull), .fifo_afull(fifo_afull),
        .out_din(out_din), .out_wren(out_wren), .out_EOD(out_EOD), .out_abort(out_abort),
        .stat_valid(stat_valid), .stat_len(stat_len), .stat_runt(stat_runt),
        .stat_long(stat_long), .stat_ovf(stat_ovf), .stat_dis(stat_dis),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #10 REF_CLK = ~REF_CLK;

    typedef struct {
        logic wren;
        logic [7:0] din;
        logic eod, abort, sv, afull;
        logic [LEN_W-1:0] len;
        logic runt, lng, ovf, dis;
        logic [15:0] fc, dc;
    } exp_t;

    exp_t q[$];
    exp_t ce;
    int errors = 0, checks = 0, wr_seen = 0;
    logic [LEN_W-1:0] m_len = '0;
    logic m_runt = 0, m_lng = 0, m_ovf = 0, m_dis = 0, pend_good = 0, pend_bad = 0;
    logic [15:0] m_fc = '0, m_dc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge REF_CLK) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            if (out_wren === 1'b1)
                wr_seen++;
            chk("out_wren", out_wren, ce.wren);
            if (ce.wren) begin
                chk("out_din", out_din, ce.din);
                chk("out_EOD", out_EOD, ce.eod);
                chk("out_abort", out_abort, ce.abort);
            end
            chk("stat_valid", stat_valid, ce.sv);
            chk("rx_afull", rx_afull, ce.afull);
            chk("stat_len", stat_len, ce.len);
            chk("stat_flags", {stat_runt, stat_long, stat_ovf, stat_dis}, {ce.runt, ce.lng, ce.ovf, ce.dis});
            chk("frame_cnt", frame_cnt, ce.fc);
            chk("drop_cnt", drop_cnt, ce.dc);
        end
    end

    // one input cycle; the queued record is what the outputs must show after this edge
    task automatic step(input logic w, input logic [7:0] d, input logic eod, input logic af,
                        input logic en, input logic ew, input logic [7:0] ed, input logic ee,
                        input logic ea, input logic rep, input logic drop);
        exp_t e;
        @(negedge REF_CLK);
        #1;
        in_wren = w; in_din = d; in_EOD = eod; fifo_afull = af; rx_en = en;
`ifdef RX_FRAME_CNT_EN
        if (pend_good && m_fc != 16'hFFFF) m_fc++;
        if (pend_bad && m_dc != 16'hFFFF) m_dc++;
`endif
        pend_good = rep && !(m_runt | m_lng | m_ovf | m_dis);
        pend_bad  = rep && (m_runt | m_lng | m_ovf | m_dis);
        e.wren = ew; e.din = ed; e.eod = ee; e.abort = ea; e.sv = rep; e.afull = af | drop;
        e.len = m_len; e.runt = m_runt; e.lng = m_lng; e.ovf = m_ovf; e.dis = m_dis;
        e.fc = m_fc; e.dc = m_dc;
        q.push_back(e);
    endtask

    task automatic idle(input logic en, input logic drop);
        step(1'b0, 8'($urandom), 1'b0, 1'($urandom), en, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, drop);
    endtask

    // k = first byte that aborts the frame (afull or MAX_LEN+1), 0 if none
    task automatic send_frame(input int L, input logic en, input int af_at, input logic toggle,
                              input logic seq, input logic no_eod);
        int k;
        logic last, drop_a, af, ew, rep, en_i;
        logic [7:0] d;
        k = 0;
        drop_a = 1'b0;
        if (en)
            for (int i = 1; i <= L; i++)
                if (k == 0 && (i == af_at || i == MAX_LEN + 1)) k = i;
        for (int i = 1; i <= L; i++) begin
            if (i > 1 && $urandom_range(0, 9) == 0)
                idle(toggle ? 1'($urandom) : en, drop_a);
            last = (i == L) && !no_eod;
            af = (i == af_at) || ((!en || (k != 0 && i > k)) && $urandom_range(0, 1) == 1);
            d = seq ? 8'(i - 1) : 8'($urandom);
            en_i = (i == 1 || !toggle) ? en : 1'($urandom);
            ew = en && (k == 0 || i <= k);
            rep = en ? (i == k || (last && k == 0)) : last;
            if (rep) begin
                m_len  = (i > SAT) ? LEN_W'(SAT) : LEN_W'(i);
                m_runt = en && k == 0 && L < MIN_LEN;
                m_lng  = en && k == MAX_LEN + 1;
                m_ovf  = en && k != 0 && k == af_at;
                m_dis  = !en;
            end
            drop_a = !last && (!en || (k != 0 && i >= k));
            step(1'b1, d, last, af, en_i, ew, (i == k) ? 8'h00 : d, ew && (i == k || last),
                 ew && (i == k || (last && L < MIN_LEN)), rep, drop_a);
        end
        idle(en, drop_a);
        idle(en, drop_a);
    endtask

    task automatic chk_cnt(input string name, input int fc, input int dc);
`ifdef RX_FRAME_CNT_EN
        chk({name, "_fc"}, frame_cnt, fc);
        chk({name, "_dc"}, drop_cnt, dc);
`else
        chk({name, "_fc"}, frame_cnt, 0);
        chk({name, "_dc"}, drop_cnt, 0);
`endif
    endtask

    initial begin
        int w0, L, af_at;
        logic en;
        #1 arst_n = 1'b0;
        #2;
        chk("rst_out", {out_wren, out_EOD, out_abort, stat_valid, out_din}, 0);
        chk("rst_stat", {stat_len, stat_runt, stat_long, stat_ovf, stat_dis}, 0);
        chk_cnt("rst", 0, 0);
        fifo_afull = 1'b1;
        #1 chk("rst_afull_hi", rx_afull, 1);
        fifo_afull = 1'b0;
        #1 chk("rst_afull_lo", rx_afull, 0);
        repeat (2) @(negedge REF_CLK);
        #2 arst_n = 1'b1;

        w0 = wr_seen;
        send_frame(64, 1, 0, 0, 1, 0);
        chk("s1_writes", wr_seen - w0, 64);
        chk("s1_len", stat_len, 64);
        chk("s1_flags", {stat_runt, stat_long, stat_ovf, stat_dis}, 0);
        chk_cnt("s1", 1, 0);

        w0 = wr_seen;
        send_frame(20, 1, 0, 0, 0, 0);
        chk("s2_writes", wr_seen - w0, 20);
        chk("s2_len", stat_len, 20);
        chk("s2_runt", stat_runt, 1);
        chk_cnt("s2", 1, 1);

        w0 = wr_seen;
        send_frame(1600, 1, 0, 0, 0, 0);
        chk("s3_writes", wr_seen - w0, 1519);
        chk("s3_len", stat_len, 1519);
        chk("s3_long", {stat_long, stat_ovf}, 2'b10);

        w0 = wr_seen;
        send_frame(100, 1, 50, 0, 0, 0);
        chk("s4_writes", wr_seen - w0, 50);
        chk("s4_len", stat_len, 50);
        chk("s4_ovf", {stat_runt, stat_long, stat_ovf}, 3'b001);
        send_frame(64, 1, 0, 0, 0, 0);
        chk("s4b_flags", {stat_runt, stat_long, stat_ovf, stat_dis}, 0);

        w0 = wr_seen;
        send_frame(80, 0, 0, 1, 0, 0);
        chk("s5_writes", wr_seen - w0, 0);
        chk("s5_len", stat_len, 80);
        chk("s5_dis", stat_dis, 1);
        send_frame(64, 1, 0, 1, 0, 0);
        chk_cnt("s5", 3, 4);

        send_frame(2100, 0, 0, 1, 0, 0);
        chk("sat_len", stat_len, SAT);
        send_frame(1, 1, 0, 0, 0, 0);
        chk("one_byte_runt", {stat_len, stat_runt}, {11'd1, 1'b1});
        send_frame(1, 0, 0, 0, 0, 0);
        chk("one_byte_dis", {stat_len, stat_dis}, {11'd1, 1'b1});
        send_frame(59, 1, 0, 0, 0, 0);
        chk("len59_runt", stat_runt, 1);
        send_frame(60, 1, 0, 0, 0, 0);
        chk("len60_ok", stat_runt, 0);
        send_frame(1518, 1, 0, 0, 0, 0);
        chk("len1518_ok", {stat_len, stat_long}, {11'd1518, 1'b0});
        send_frame(70, 1, 70, 0, 0, 0);
        chk("afull_at_eod", {stat_ovf, stat_runt, stat_len}, {1'b1, 1'b0, 11'd70});

        for (int f = 0; f < 40; f++) begin
            L = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 200);
            en = $urandom_range(0, 3) != 0;
            af_at = (en && L >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(2, L) : 0;
            send_frame(L, en, af_at, 1'($urandom), 0, 0);
        end

        send_frame(30, 1, 0, 0, 1, 1);
        @(negedge REF_CLK);
        #3 arst_n = 1'b0;
        #1;
        chk("mid_rst_out", {out_wren, out_EOD, out_abort, stat_valid, out_din}, 0);
        chk("mid_rst_stat", {stat_len, stat_runt, stat_long, stat_ovf, stat_dis}, 0);
        chk("mid_rst_cnt", {frame_cnt, drop_cnt}, 0);
        m_len = '0; m_runt = 0; m_lng = 0; m_ovf = 0; m_dis = 0;
        m_fc = '0; m_dc = '0; pend_good = 0; pend_bad = 0;
        repeat (2) @(negedge REF_CLK);
        #2 arst_n = 1'b1;
        w0 = wr_seen;
        send_frame(34, 1, 0, 0, 0, 0);
        chk("post_rst_writes", wr_seen - w0, 34);
        chk("post_rst_len", stat_len, 34);
        chk_cnt("post_rst", 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
